// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic stall_fetch;
        logic stall_dec;
        logic stall_exec;
        logic stall_mem;
        logic flush_dec;
        logic flush_exec;
    } hazard_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination feeds either source of the DEC instruction.
// Purely combinational; x0 never creates a dependency.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  hazard_o
);

    assign hazard_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: merges I/D-miss, load-use and mispredict into one control set.
// Outputs are combinational from the registered state; stall counter updates one cycle later.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = pipeline_hazard_ctrl_pkg::REG_ADDR_W,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  imiss_i,
    input  logic                  imem_ready_i,
    input  logic                  dmiss_i,
    input  logic                  dmem_ready_i,
    input  logic                  mem_read_exec_i,
    input  logic [REG_ADDR_W-1:0] rd_exec_i,
    input  logic [REG_ADDR_W-1:0] rs1_dec_i,
    input  logic [REG_ADDR_W-1:0] rs2_dec_i,
    input  logic                  mispred_exec_i,
    output logic                  stall_fetch_o,
    output logic                  stall_dec_o,
    output logic                  stall_exec_o,
    output logic                  stall_mem_o,
    output logic                  flush_dec_o,
    output logic                  flush_exec_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    hazard_state_t        state_q, state_d;
    logic                 redir_q, redir_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    hazard_ctrl_t         ctrl;
    logic                 load_use;
    logic                 any_stall;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .mem_read_i (mem_read_exec_i),
        .rd_i       (rd_exec_i),
        .rs1_i      (rs1_dec_i),
        .rs2_i      (rs2_dec_i),
        .hazard_o   (load_use)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= RUN;
            redir_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        redir_d = redir_q;
        ctrl    = '0;
        case (state_q)
            RUN: begin
                redir_d = 1'b0;
                if (mispred_exec_i) begin
                    ctrl.flush_dec  = 1'b1;
                    ctrl.flush_exec = 1'b1;
                end else if (load_use) begin
                    ctrl.stall_fetch = 1'b1;
                    ctrl.stall_dec   = 1'b1;
                    ctrl.flush_exec  = 1'b1;
                end
                if (dmiss_i) begin
                    state_d = DMISS;
                end else if (imiss_i) begin
                    state_d = IMISS;
                end
            end
            IMISS: begin
                ctrl.stall_fetch = 1'b1;
                if (mispred_exec_i) begin
                    ctrl.flush_dec  = 1'b1;
                    ctrl.flush_exec = 1'b1;
                end else if (imem_ready_i && redir_q) begin
                    // Refill was wrong-path: kill decode even if a load-use wanted to hold it.
                    ctrl.flush_dec  = 1'b1;
                    ctrl.flush_exec = load_use;
                end else if (load_use) begin
                    ctrl.stall_dec  = 1'b1;
                    ctrl.flush_exec = 1'b1;
                end else begin
                    ctrl.flush_dec = 1'b1;
                end
                if (mispred_exec_i) begin
                    redir_d = 1'b1;
                end
                if (imem_ready_i) begin
                    redir_d = 1'b0;
                end
                if (dmiss_i) begin
                    state_d = DMISS;
                end else if (imem_ready_i) begin
                    state_d = RUN;
                end
            end
            DMISS: begin
                ctrl.stall_fetch = 1'b1;
                ctrl.stall_dec   = 1'b1;
                ctrl.stall_exec  = 1'b1;
                ctrl.stall_mem   = 1'b1;
                if (dmem_ready_i) begin
                    state_d = imiss_i ? IMISS : RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (arst_i) begin
            ctrl = '0;
        end

        any_stall = ctrl.stall_fetch | ctrl.stall_dec | ctrl.stall_exec | ctrl.stall_mem;
        cnt_d     = cnt_q;
        if (any_stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_fetch_o = ctrl.stall_fetch;
    assign stall_dec_o   = ctrl.stall_dec;
    assign stall_exec_o  = ctrl.stall_exec;
    assign stall_mem_o   = ctrl.stall_mem;
    assign flush_dec_o   = ctrl.flush_dec;
    assign flush_exec_o  = ctrl.flush_exec;
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized miss/hazard traffic checked against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic       imiss_i, imem_ready_i, dmiss_i, dmem_ready_i;
    logic       mem_read_exec_i, mispred_exec_i;
    logic [4:0] rd_exec_i, rs1_dec_i, rs2_dec_i;

    logic        sf, sd, se, sm, fd, fe;
    logic [31:0] cnt32;
    logic        sf4, sd4, se4, sm4, fd4, fe4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic        m_in_imiss, m_in_dmiss, m_redir;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;

    logic [5:0]  last_ctrl;
    logic [31:0] last_cnt;
    logic [3:0]  last_cnt4;
    int          obs_mem_stalls;
    int          obs_lu_cycles;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl u_dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .imiss_i(imiss_i), .imem_ready_i(imem_ready_i),
        .dmiss_i(dmiss_i), .dmem_ready_i(dmem_ready_i),
        .mem_read_exec_i(mem_read_exec_i), .rd_exec_i(rd_exec_i),
        .rs1_dec_i(rs1_dec_i), .rs2_dec_i(rs2_dec_i),
        .mispred_exec_i(mispred_exec_i),
        .stall_fetch_o(sf), .stall_dec_o(sd), .stall_exec_o(se), .stall_mem_o(sm),
        .flush_dec_o(fd), .flush_exec_o(fe), .stall_cnt_o(cnt32)
    );

    pipeline_hazard_ctrl #(.CNT_WIDTH(4)) u_dut_sat (
        .clk_i(clk_i), .arst_i(arst_i),
        .imiss_i(imiss_i), .imem_ready_i(imem_ready_i),
        .dmiss_i(dmiss_i), .dmem_ready_i(dmem_ready_i),
        .mem_read_exec_i(mem_read_exec_i), .rd_exec_i(rd_exec_i),
        .rs1_dec_i(rs1_dec_i), .rs2_dec_i(rs2_dec_i),
        .mispred_exec_i(mispred_exec_i),
        .stall_fetch_o(sf4), .stall_dec_o(sd4), .stall_exec_o(se4), .stall_mem_o(sm4),
        .flush_dec_o(fd4), .flush_exec_o(fe4), .stall_cnt_o(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Expected {stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec}.
    function automatic logic [5:0] model_out();
        logic hz;
        logic [5:0] e;
        hz = mem_read_exec_i && (rd_exec_i != 0) &&
             (rd_exec_i == rs1_dec_i || rd_exec_i == rs2_dec_i);
        e = 6'b000000;
        if (arst_i)                       e = 6'b000000;
        else if (m_in_dmiss)              e = 6'b111100;
        else if (m_in_imiss) begin
            if (mispred_exec_i)           e = 6'b100011;
            else if (imem_ready_i && m_redir) e = {5'b10001, hz};
            else if (hz)                  e = 6'b110001;
            else                          e = 6'b100010;
        end else begin
            if (mispred_exec_i)           e = 6'b000011;
            else if (hz)                  e = 6'b110001;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_in_imiss = 1'b0;
        m_in_dmiss = 1'b0;
        m_redir    = 1'b0;
        m_cnt      = '0;
        m_cnt4     = '0;
    endtask

    task automatic model_update(input logic [5:0] e);
        if (arst_i) begin
            model_reset();
        end else begin
            if (|e[5:2]) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt4 != 4'hF)         m_cnt4 = m_cnt4 + 1;
            end
            if (m_in_dmiss) begin
                if (dmem_ready_i) begin
                    m_in_dmiss = 1'b0;
                    m_in_imiss = imiss_i;
                end
            end else if (m_in_imiss) begin
                if (imem_ready_i)        m_redir = 1'b0;
                else if (mispred_exec_i) m_redir = 1'b1;
                if (dmiss_i) begin
                    m_in_dmiss = 1'b1;
                    m_in_imiss = 1'b0;
                end else if (imem_ready_i) begin
                    m_in_imiss = 1'b0;
                end
            end else begin
                m_redir = 1'b0;
                if (dmiss_i)      m_in_dmiss = 1'b1;
                else if (imiss_i) m_in_imiss = 1'b1;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic [5:0] e;
        @(negedge clk_i);
        e = model_out();
        last_ctrl = {sf, sd, se, sm, fd, fe};
        last_cnt  = cnt32;
        last_cnt4 = cnt4;
        if (sm) obs_mem_stalls++;
        if (sf && sd && fe && !fd) obs_lu_cycles++;
        chk("ctrl", {26'd0, last_ctrl}, {26'd0, e});
        chk("cnt32", cnt32, m_cnt);
        chk("cnt4", {28'd0, cnt4}, {28'd0, m_cnt4});
        @(posedge clk_i);
        model_update(e);
        #1;
    endtask

    task automatic idle();
        imiss_i = 0; imem_ready_i = 0; dmiss_i = 0; dmem_ready_i = 0;
        mem_read_exec_i = 0; mispred_exec_i = 0;
        rd_exec_i = 0; rs1_dec_i = 0; rs2_dec_i = 0;
    endtask

    // Entered just after a rising edge; asserts reset between edges.
    task automatic reset_pulse();
        #2;
        arst_i = 1'b1;
        #1;
        chk("rst_ctrl", {26'd0, sf, sd, se, sm, fd, fe}, 32'd0);
        chk("rst_cnt", cnt32, 32'd0);
        chk("rst_cnt4", {28'd0, cnt4}, 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        idle();
    endtask

    initial begin
        logic [31:0] cnt_before;
        arst_i = 1'b1;
        idle();
        model_reset();
        last_ctrl = '0; last_cnt = '0; last_cnt4 = '0;
        obs_mem_stalls = 0; obs_lu_cycles = 0;
        mem_read_exec_i = 1; rd_exec_i = 5; rs1_dec_i = 5;
        #3;
        chk("por_ctrl", {26'd0, sf, sd, se, sm, fd, fe}, 32'd0);
        chk("por_cnt", cnt32, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        idle();
        tick();

        // T1: load-use stalls exactly one cycle; rd=0 never stalls
        obs_lu_cycles = 0;
        mem_read_exec_i = 1; rd_exec_i = 5; rs1_dec_i = 5; rs2_dec_i = 3;
        tick();
        idle();
        tick(); tick();
        chk("t1_lu_cycles", obs_lu_cycles, 1);
        mem_read_exec_i = 1; rd_exec_i = 0; rs1_dec_i = 0; rs2_dec_i = 0;
        tick();
        chk("t1_rd0", {26'd0, last_ctrl}, 32'd0);
        mem_read_exec_i = 1; rd_exec_i = 9; rs1_dec_i = 1; rs2_dec_i = 9;
        tick();
        chk("t1_rs2", {26'd0, last_ctrl}, {26'd0, 6'b110001});
        idle();

        // T2: D-miss seen in RUN, 10 frozen cycles, then the ready cycle (also frozen)
        dmiss_i = 1;
        tick();
        cnt_before = last_cnt;
        obs_mem_stalls = 0;
        for (int c = 0; c < 10; c++) begin
            mispred_exec_i = (c == 4);
            mem_read_exec_i = (c == 6); rd_exec_i = 2; rs1_dec_i = 2;
            tick();
        end
        idle();
        dmiss_i = 1; dmem_ready_i = 1;
        tick();
        idle();
        tick();
        chk("t2_stall_cycles", obs_mem_stalls, 11);
        chk("t2_cnt_delta", last_cnt - cnt_before, 11);

        // T3: I-miss with mispredict at cycle 3, refill at cycle 8
        for (int c = 0; c <= 8; c++) begin
            imiss_i = 1;
            mispred_exec_i = (c == 3);
            imem_ready_i = (c == 8);
            tick();
            if (c == 3) chk("t3_flush_exec", {31'd0, last_ctrl[0]}, 1);
            if (c == 8) chk("t3_flush_dec_ready", {31'd0, last_ctrl[1]}, 1);
        end
        idle();
        tick();
        chk("t3_back_run", {26'd0, last_ctrl}, 32'd0);

        // T4: mispredict beats load-use; simultaneous misses go D first, then I
        mispred_exec_i = 1; mem_read_exec_i = 1; rd_exec_i = 7; rs1_dec_i = 7;
        tick();
        chk("t4_mp_over_lu", {26'd0, last_ctrl}, {26'd0, 6'b000011});
        idle();
        dmiss_i = 1; imiss_i = 1;
        tick();
        tick(); tick();
        chk("t4_dmiss_first", {26'd0, last_ctrl}, {26'd0, 6'b111100});
        dmem_ready_i = 1;
        tick();
        dmem_ready_i = 0; dmiss_i = 0;
        tick();
        chk("t4_then_imiss", {26'd0, last_ctrl}, {26'd0, 6'b100010});
        imem_ready_i = 1;
        tick();
        idle();
        tick();

        // T5: reset while in DMISS with a pending redirect
        imiss_i = 1;
        tick();
        mispred_exec_i = 1;
        tick();
        mispred_exec_i = 0; dmiss_i = 1;
        tick();
        mem_read_exec_i = 1; rd_exec_i = 4; rs1_dec_i = 4;
        tick();
        reset_pulse();
        tick();
        chk("t5_run_after_rst", {26'd0, last_ctrl}, 32'd0);
        imiss_i = 1;
        tick();
        imem_ready_i = 1; mem_read_exec_i = 1; rd_exec_i = 4; rs1_dec_i = 4;
        tick();
        chk("t5_redir_cleared", {26'd0, last_ctrl}, {26'd0, 6'b110001});
        idle();
        tick();

        // T6: 20 stalled cycles saturate the 4-bit counter
        dmiss_i = 1;
        for (int c = 0; c < 21; c++) tick();
        dmem_ready_i = 1;
        tick();
        idle();
        tick();
        chk("t6_sat", {28'd0, last_cnt4}, 32'd15);

        // Randomized traffic respecting the held-until-ready miss protocol
        for (int c = 0; c < 3000; c++) begin
            if (imem_ready_i) begin
                imem_ready_i = 0; imiss_i = 0;
            end else if (imiss_i) begin
                imem_ready_i = ($urandom_range(0, 5) == 0);
            end else begin
                imiss_i = ($urandom_range(0, 9) == 0);
            end
            if (dmem_ready_i) begin
                dmem_ready_i = 0; dmiss_i = 0;
            end else if (dmiss_i) begin
                dmem_ready_i = ($urandom_range(0, 5) == 0);
            end else begin
                dmiss_i = ($urandom_range(0, 14) == 0);
            end
            mem_read_exec_i = ($urandom_range(0, 2) == 0);
            mispred_exec_i  = ($urandom_range(0, 7) == 0);
            rd_exec_i  = 5'($urandom_range(0, 5));
            rs1_dec_i  = 5'($urandom_range(0, 5));
            rs2_dec_i  = 5'($urandom_range(0, 5));
            if ($urandom_range(0, 399) == 0) begin
                reset_pulse();
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
